byte_word_reader: RTL and testbench
===================================

# byte_word_reader

Bus-side reader that fills a temporary register from an 8-bit memory/IO bus. On a start pulse it performs one (byte) or two (word) byte-wide read cycles with a request/acknowledge handshake, assembles the result little-endian into a 16-bit value, and presents it as a one-cycle write (`wr_val`/`wr_en`) to the downstream temporary register. It sits between the microcode sequencer and the 8-bit external bus interface.

## Interface
- `AW`, default 20: bus address width.
- `clk  in  1`: clock; all logic on the rising edge.
- `reset_n  in  1`: one clock; reset is asynchronous and active-low.
- `start  in  1`: single-cycle request; sampled only in IDLE.
- `addr  in  AW`: address of the low byte; captured on accepted `start`.
- `is_8bit  in  1`: 1 = byte read, zero-extended; 0 = word read. Captured with `start`.
- `busy  out  1`: high from the cycle after an accepted `start` through the `wr_en` cycle inclusive.
- `b_addr  out  AW`: bus address.
- `b_access  out  1`: bus request; held high until acknowledged.
- `b_rdata  in  8`: bus read data; valid in a `b_ack` cycle.
- `b_ack  in  1`: bus acknowledge; ignored while `b_access` is low.
- `wr_val  out  16`: assembled value; registered, holds until the next completion.
- `wr_en  out  1`: one-cycle write strobe to the temp register.

## Operation
- States: IDLE, LO, TURN, HI, DONE.
- IDLE: `start`=1 -> capture `addr`, `is_8bit`; go LO. Otherwise stay.
- LO: `b_access`=1, `b_addr`=captured addr. On `b_ack`: latch `b_rdata` into low byte; go DONE if byte, else TURN.
- TURN: `b_access`=0 for exactly one cycle (bus turnaround); `b_addr` = addr+1; go HI.
- HI: `b_access`=1, `b_addr`=addr+1 modulo 2^AW (0xFFFFF wraps to 0x00000). On `b_ack`: latch `b_rdata` into high byte; go DONE.
- DONE: `wr_en`=1 for one cycle; `wr_val` = {hi, lo} (word) or {8'h00, lo} (byte); go IDLE.
- `start` in any non-IDLE state is ignored and not queued; a `start` in the DONE cycle is also ignored.
- `b_addr` and captured data registers are internal-only in IDLE; `b_addr` holds its last value there.
- Reset (any state, any time, including mid-bus-cycle): state IDLE; `busy`=0, `b_access`=0, `wr_en`=0, `wr_val`=16'h0000, `b_addr`=0. A pending bus cycle is abandoned; no `wr_en` is produced for it.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- `start` accepted in cycle 0 -> `b_access` and `busy` high in cycle 1.
- `b_ack` in the same cycle `b_access` is first high is legal (zero wait states).
- Byte, zero wait: ack cycle 1 -> `wr_en` cycle 2; `busy` cycles 1–2.
- Word, zero wait: lo ack cycle 1, TURN cycle 2, hi access/ack cycle 3, `wr_en` cycle 4; `busy` cycles 1–4.
- Each wait state (`b_access` high, `b_ack` low) adds one cycle; `b_addr` stable throughout.
- Earliest next accepted `start` is the cycle after `wr_en`.
- `wr_val` changes only in the `wr_en` cycle (or reset).

## Test plan
- Reset: assert `reset_n`=0 mid-HI -> all outputs 0 next edge-independent; after release no `wr_en`, IDLE accepts new `start`.
- Byte read: addr 0x01234, is_8bit=1, ack same cycle with 0xA5 -> `b_addr`=0x01234, `wr_en` cycle 2, `wr_val`=0x00A5.
- Word read, zero wait: addr 0x00100, bytes 0x34 then 0x12 -> `b_addr` 0x00100 then 0x00101, one low cycle between, `wr_en` cycle 4, `wr_val`=0x1234.
- Wait states: word read with 3 wait cycles on each byte -> `b_access`/`b_addr` stable while waiting, `wr_en` cycle 10, `busy` continuous cycles 1–10.
- Address wrap: addr 0xFFFFF word read -> hi byte at 0x00000; bytes 0xEF, 0xBE -> `wr_val`=0xBEEF.
- Start while busy: pulse `start` in LO, TURN, and DONE cycles -> exactly one `wr_en`; stray `b_ack` with `b_access`=0 in TURN -> ignored, result unchanged.

Source files
------------

// File: rtl/byte_word_reader_if.sv
// Byte-wide request/acknowledge bus between the reader and the external bus interface.
interface byte_word_reader_if #(
    parameter int AW = 20
);
    logic [AW-1:0] b_addr;
    logic          b_access;
    logic [7:0]    b_rdata;
    logic          b_ack;

    modport master (output b_addr, output b_access, input b_rdata, input b_ack);
    modport slave  (input b_addr, input b_access, output b_rdata, output b_ack);
endinterface

// File: rtl/byte_word_reader.sv
// Reads one or two bytes over the 8-bit bus, assembles them little-endian and
// issues a single-cycle write of the 16-bit result to the temp register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; b_addr holds its last value
// LO    | bus request for the low byte at the captured address
// TURN  | one-cycle bus turnaround, b_access low, b_addr = addr+1
// HI    | bus request for the high byte at addr+1
// DONE  | wr_en pulse with the assembled value
module byte_word_reader #(
    parameter int AW = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [AW-1:0]      addr,
    input  logic               is_8bit,
    output logic               busy,
    byte_word_reader_if.master bus,
    output logic [15:0]        wr_val,
    output logic               wr_en
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        TURN = 3'd2,
        HI   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] b_addr_q, b_addr_d;
    logic          b_access_q, b_access_d;
    logic          busy_q, busy_d;
    logic          wr_en_q, wr_en_d;
    logic [15:0]   wr_val_q, wr_val_d;
    logic [7:0]    lo_q, lo_d;
    logic          is8_q, is8_d;

    // Every output is a flop loaded from the next-state decode, so no input
    // reaches an output without passing through a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            b_addr_q   <= '0;
            b_access_q <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_val_q   <= 16'h0000;
            lo_q       <= 8'h00;
            is8_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            b_addr_q   <= b_addr_d;
            b_access_q <= b_access_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_val_q   <= wr_val_d;
            lo_q       <= lo_d;
            is8_q      <= is8_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = LO;
            LO:   if (bus.b_ack) state_d = is8_q ? DONE : TURN;
            TURN: state_d = HI;
            HI:   if (bus.b_ack) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d     = (state_d != IDLE);
        b_access_d = (state_d == LO) || (state_d == HI);
        wr_en_d    = (state_d == DONE);
        b_addr_d   = b_addr_q;
        wr_val_d   = wr_val_q;
        lo_d       = lo_q;
        is8_d      = is8_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    b_addr_d = addr;
                    is8_d    = is_8bit;
                end
            end
            LO: begin
                if (bus.b_ack) begin
                    lo_d = bus.b_rdata;
                    if (is8_q) wr_val_d = {8'h00, bus.b_rdata};
                    else       b_addr_d = b_addr_q + AW'(1);
                end
            end
            HI: begin
                if (bus.b_ack) wr_val_d = {bus.b_rdata, lo_q};
            end
            default: ;
        endcase
    end

    assign bus.b_addr   = b_addr_q;
    assign bus.b_access = b_access_q;
    assign busy         = busy_q;
    assign wr_en        = wr_en_q;
    assign wr_val       = wr_val_q;

endmodule

// File: tb/tb_byte_word_reader.sv
// Self-checking bench for byte_word_reader: directed table, reset-in-HI sequence
// and randomized transactions against a transaction-level reference model.
module tb_byte_word_reader;

    localparam int AW = 20;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] addr;
    logic          is_8bit;
    logic          busy;
    logic [15:0]   wr_val;
    logic          wr_en;

    byte_word_reader_if #(.AW(AW)) bus ();

    byte_word_reader #(.AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .addr    (addr),
        .is_8bit (is_8bit),
        .busy    (busy),
        .bus     (bus),
        .wr_val  (wr_val),
        .wr_en   (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          is8;
        logic [7:0]    b0;
        logic [7:0]    b1;
        int            w0;
        int            w1;
        bit            stray;
        bit            sbusy;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [15:0]   val;
        int            cyc;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: value, completion cycle and bus addresses.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int unsigned nxt;
        r     = v;
        nxt   = (32'(v.addr) + 1) % (32'd1 << AW);
        r.a0  = v.addr;
        r.a1  = AW'(nxt);
        r.val = v.is8 ? {8'h00, v.b0} : {v.b1, v.b0};
        r.cyc = v.is8 ? 2 + v.w0 : 4 + v.w0 + v.w1;
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int          phase, wcnt, gap, addr_bad, busy_bad, val_chg, wr_cyc, extra;
        logic [15:0] prev_val, got_val;
        phase = 0; wcnt = 0; gap = 0; addr_bad = 0; busy_bad = 0;
        val_chg = 0; wr_cyc = -1; extra = 0; got_val = '0;
        @(posedge clk); #1;
        start = 1'b1; addr = v.addr; is_8bit = v.is8; bus.b_ack = 1'b0;
        prev_val = wr_val;
        for (int c = 1; c <= 80 && wr_cyc < 0; c++) begin
            @(posedge clk); #1;
            bus.b_ack   = 1'b0;
            bus.b_rdata = 8'($urandom);
            start       = v.sbusy && (busy === 1'b1);
            if (busy !== 1'b1) busy_bad++;
            if (wr_en === 1'b1) begin
                wr_cyc  = c;
                got_val = wr_val;
            end else begin
                if (wr_val !== prev_val) val_chg++;
                if (bus.b_access === 1'b1) begin
                    if (phase == 0) begin
                        if (bus.b_addr !== v.a0) addr_bad++;
                        if (wcnt == v.w0) begin
                            bus.b_ack = 1'b1; bus.b_rdata = v.b0;
                            phase = v.is8 ? 2 : 1; wcnt = 0;
                        end else wcnt++;
                    end else begin
                        if (bus.b_addr !== v.a1) addr_bad++;
                        if (wcnt == v.w1) begin
                            bus.b_ack = 1'b1; bus.b_rdata = v.b1; phase = 2;
                        end else wcnt++;
                    end
                end else if (phase == 1) begin
                    gap++;
                    if (v.stray) bus.b_ack = 1'b1;
                end
            end
        end
        chk("wr_cycle", wr_cyc, v.cyc);
        chk("wr_val", {16'h0, got_val}, {16'h0, v.val});
        chk("b_addr", addr_bad, 0);
        chk("turn_gap", gap, v.is8 ? 0 : 1);
        chk("busy_span", busy_bad, 0);
        chk("val_hold", val_chg, 0);
        chk("phases", phase, 2);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0; bus.b_ack = 1'b0;
            if (wr_en === 1'b1 || busy === 1'b1 || bus.b_access === 1'b1) extra++;
        end
        chk("idle_after", extra, 0);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{20'h01234, 1'b1, 8'hA5, 8'h00, 0, 0, 1'b0, 1'b0, 20'h01234, 20'h01235, 16'h00A5, 2};
        tbl[1] = '{20'h00100, 1'b0, 8'h34, 8'h12, 0, 0, 1'b0, 1'b0, 20'h00100, 20'h00101, 16'h1234, 4};
        tbl[2] = '{20'h0ABC0, 1'b0, 8'hC3, 8'h3C, 3, 3, 1'b0, 1'b0, 20'h0ABC0, 20'h0ABC1, 16'h3CC3, 10};
        tbl[3] = '{20'hFFFFF, 1'b0, 8'hEF, 8'hBE, 0, 0, 1'b0, 1'b0, 20'hFFFFF, 20'h00000, 16'hBEEF, 4};
        tbl[4] = '{20'h00200, 1'b0, 8'h11, 8'h22, 1, 0, 1'b1, 1'b1, 20'h00200, 20'h00201, 16'h2211, 5};
        tbl[5] = '{20'h7FFFF, 1'b1, 8'h80, 8'hFF, 2, 0, 1'b0, 1'b1, 20'h7FFFF, 20'h80000, 16'h0080, 4};

        reset_n = 1'b0; start = 1'b0; addr = '0; is_8bit = 1'b0;
        bus.b_ack = 1'b0; bus.b_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_access", {31'h0, bus.b_access}, 0);
        chk("rst_wr_en", {31'h0, wr_en}, 0);
        chk("rst_wr_val", {16'h0, wr_val}, 0);
        chk("rst_b_addr", {12'h0, bus.b_addr}, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Reset asserted while the high-byte request is outstanding.
        @(posedge clk); #1;
        start = 1'b1; addr = 20'h0ABCD; is_8bit = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_lo_access", {31'h0, bus.b_access}, 1);
        bus.b_ack = 1'b1; bus.b_rdata = 8'h77;
        @(posedge clk); #1;
        bus.b_ack = 1'b0;
        chk("mid_turn_access", {31'h0, bus.b_access}, 0);
        @(posedge clk); #1;
        chk("mid_hi_access", {31'h0, bus.b_access}, 1);
        chk("mid_hi_addr", {12'h0, bus.b_addr}, 32'h0ABCE);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'h0, busy}, 0);
        chk("arst_access", {31'h0, bus.b_access}, 0);
        chk("arst_wr_en", {31'h0, wr_en}, 0);
        chk("arst_wr_val", {16'h0, wr_val}, 0);
        chk("arst_b_addr", {12'h0, bus.b_addr}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int stray_wr;
            stray_wr = 0;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                if (wr_en === 1'b1 || busy === 1'b1) stray_wr++;
            end
            chk("post_rst_quiet", stray_wr, 0);
        end
        run_txn(tbl[1]);

        for (int n = 0; n < 40; n++) begin
            rv.addr  = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : AW'($urandom);
            rv.is8   = 1'($urandom_range(0, 1));
            rv.b0    = 8'($urandom);
            rv.b1    = 8'($urandom);
            rv.w0    = $urandom_range(0, 4);
            rv.w1    = $urandom_range(0, 4);
            rv.stray = 1'($urandom_range(0, 1));
            rv.sbusy = 1'($urandom_range(0, 1));
            rv = model(rv);
            run_txn(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
